// File: rtl/scan_frame_capture.sv
// scan_frame_capture
//
// Captures a 10x10 LED matrix frame by watching the scan lines of an
// external display driver. Row strobes and column data arrive
// asynchronously, are synchronized, and a combined scan word is accepted
// only after it has been stable for STABLE_CYCLES clocks. Accepted rows
// are written into a capture buffer in strict 0..9 order; writing row 9
// commits the whole frame to a read buffer in a single edge.
//
// Ports
//   clk            system clock, all state changes on the rising edge
//   rst_n          asynchronous active-low reset
//   row_sel_i      row strobes, active-high, expected one-hot (async)
//   col_n_i        column data, active-low, low = LED lit (async)
//   rd_row_i       committed-frame row to read
//   rd_data_o      committed row contents, registered (1-cycle latency)
//   frame_valid_o  one-cycle pulse when a frame is committed
//   frame_count_o  committed frame counter, wraps
//   err_pulse_o    one-cycle pulse on a scan protocol error
//   err_count_o    protocol error counter, saturates at 255
//   dbg_state_o    FSM state for debug: 0 = HUNT, 1 = CAPTURE
//
// Handshake: there is no valid/ready flow control; the scan lines are
// free-running and the read port is a plain registered lookup.

module scan_frame_capture #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] row_sel_i,
    input  logic [9:0] col_n_i,
    input  logic [3:0] rd_row_i,
    output logic [9:0] rd_data_o,
    output logic       frame_valid_o,
    output logic [15:0] frame_count_o,
    output logic       err_pulse_o,
    output logic [7:0] err_count_o,
    output logic       dbg_state_o
);

    typedef enum logic {
        ST_HUNT    = 1'b0,
        ST_CAPTURE = 1'b1
    } state_t;

    localparam logic [7:0] STAB_MAX  = 8'(STABLE_CYCLES);
    localparam logic [7:0] STAB_LAST = 8'(STABLE_CYCLES - 1);

    // Synchronizers
    logic [9:0]  row_s1_q, row_s2_q;
    logic [9:0]  col_s1_q, col_s2_q;

    // Stability filter
    logic [19:0] word_prev_q;
    logic [7:0]  stab_cnt_q, stab_cnt_d;
    logic        word_same;
    logic        accept;

    // FSM and frame tracking
    state_t      state_q, state_d;
    logic [3:0]  last_row_q, last_row_d;
    logic [3:0]  expect_q, expect_d;

    // Buffers and outputs
    logic [9:0]  cap_q [0:9];
    logic [9:0]  com_q [0:9];
    logic [9:0]  rd_data_q, rd_data_d;
    logic        frame_valid_q;
    logic [15:0] frame_count_q;
    logic        err_pulse_q;
    logic [7:0]  err_count_q;

    // Decoded scan word
    logic        row_blank;
    logic        row_multi;
    logic [3:0]  row_idx;
    logic [9:0]  lit;

    // Per-edge actions decided by the FSM
    logic        wr_en;
    logic [3:0]  wr_slot;
    logic        commit;
    logic        err;

    // ------------------------------------------------------------------
    // Two-flop synchronizers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1_q <= '0;
            row_s2_q <= '0;
            col_s1_q <= '0;
            col_s2_q <= '0;
        end else begin
            row_s1_q <= row_sel_i;
            row_s2_q <= row_s1_q;
            col_s1_q <= col_n_i;
            col_s2_q <= col_s1_q;
        end
    end

    // ------------------------------------------------------------------
    // Stability filter: the counter holds the number of edges the word
    // has matched its predecessor. Acceptance is the single edge where it
    // would reach STABLE_CYCLES; it then parks there so a long-held word
    // is accepted only once.
    // ------------------------------------------------------------------
    assign word_same = ({row_s2_q, col_s2_q} == word_prev_q);
    assign accept    = word_same && (stab_cnt_q == STAB_LAST);

    always_comb begin
        stab_cnt_d = stab_cnt_q;
        if (!word_same) begin
            stab_cnt_d = '0;
        end else if (stab_cnt_q != STAB_MAX) begin
            stab_cnt_d = stab_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_prev_q <= '0;
            stab_cnt_q  <= '0;
        end else begin
            word_prev_q <= {row_s2_q, col_s2_q};
            stab_cnt_q  <= stab_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Scan word decode
    // ------------------------------------------------------------------
    assign row_blank = (row_s2_q == '0);
    // Clearing the lowest set bit leaves something only if 2+ bits are set.
    assign row_multi = |(row_s2_q & (row_s2_q - 10'd1));
    assign lit       = ~col_s2_q;

    always_comb begin
        row_idx = '0;
        for (int i = 0; i < 10; i++) begin
            if (row_s2_q[i]) row_idx = 4'(i);
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and per-edge actions
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        last_row_d = last_row_q;
        expect_d   = expect_q;
        wr_en      = 1'b0;
        wr_slot    = expect_q;
        commit     = 1'b0;
        err        = 1'b0;

        if (accept && !row_blank) begin
            if (row_multi) begin
                err     = 1'b1;
                state_d = ST_HUNT;
            end else begin
                unique case (state_q)
                    ST_HUNT: begin
                        if (row_idx == 4'd0) begin
                            wr_en      = 1'b1;
                            wr_slot    = 4'd0;
                            last_row_d = 4'd0;
                            expect_d   = 4'd1;
                            state_d    = ST_CAPTURE;
                        end
                    end
                    ST_CAPTURE: begin
                        if (row_idx == last_row_q) begin
                            // Same row re-accepted (e.g. after a glitch): ignore.
                        end else if (row_idx == expect_q) begin
                            wr_en      = 1'b1;
                            wr_slot    = expect_q;
                            last_row_d = expect_q;
                            if (expect_q == 4'd9) begin
                                expect_d = 4'd0;
                                commit   = 1'b1;
                            end else begin
                                expect_d = expect_q + 4'd1;
                            end
                        end else begin
                            err     = 1'b1;
                            state_d = ST_HUNT;
                        end
                    end
                    default: state_d = ST_HUNT;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_HUNT;
            last_row_q <= '0;
            expect_q   <= '0;
        end else begin
            state_q    <= state_d;
            last_row_q <= last_row_d;
            expect_q   <= expect_d;
        end
    end

    // ------------------------------------------------------------------
    // Capture and committed buffers. The commit takes slot 9 straight
    // from the incoming word since cap_q[9] is only updated on this edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 10; i++) begin
                cap_q[i] <= '0;
                com_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 10; i++) begin
                if (wr_en && (wr_slot == 4'(i))) cap_q[i] <= lit;
            end
            if (commit) begin
                for (int i = 0; i < 9; i++) com_q[i] <= cap_q[i];
                com_q[9] <= lit;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read port: reads old com_q on a commit edge; rows 10..15 read 0.
    // ------------------------------------------------------------------
    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < 10; i++) begin
            if (rd_row_i == 4'(i)) rd_data_d = com_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q     <= '0;
            frame_valid_q <= 1'b0;
            frame_count_q <= '0;
            err_pulse_q   <= 1'b0;
            err_count_q   <= '0;
        end else begin
            rd_data_q     <= rd_data_d;
            frame_valid_q <= commit;
            err_pulse_q   <= err;
            if (commit) frame_count_q <= frame_count_q + 16'd1;
            if (err && (err_count_q != 8'hFF)) err_count_q <= err_count_q + 8'd1;
        end
    end

    assign rd_data_o     = rd_data_q;
    assign frame_valid_o = frame_valid_q;
    assign frame_count_o = frame_count_q;
    assign err_pulse_o   = err_pulse_q;
    assign err_count_o   = err_count_q;
    assign dbg_state_o   = (state_q == ST_CAPTURE);

endmodule

// File: doc/scan_frame_capture.md
SCAN_FRAME_CAPTURE -- requirements
Module: scan_frame_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, number of consecutive clk cycles a synchronized scan word must hold before acceptance; legal range 1..255.
REQ-002 clk  input  1  system clock, 50 MHz; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset; clears all state immediately on assertion.
REQ-004 row_sel  input  10  scanned row strobes, active-high, intended one-hot; bit r = row r; asynchronous to clk.
REQ-005 col_n  input  10  scanned column data, active-low; bit c low = LED in column c lit; asynchronous to clk.
REQ-006 rd_row  input  4  row index to read from committed frame.
REQ-007 rd_data  output  10  committed frame row rd_row; bit c = 1 means lit.
REQ-008 frame_valid  output  1  one-cycle pulse on frame commit.
REQ-009 frame_count  output  16  committed frames; wraps 65535 -> 0.
REQ-010 err_pulse  output  1  one-cycle pulse on scan protocol error.
REQ-011 err_count  output  8  protocol errors; saturates at 255.

Function
REQ-012 row_sel and col_n SHALL each pass through a two-flop synchronizer; the second-stage pair forms the 20-bit scan word.
REQ-013 The stability counter SHALL reset on any scan word change and increment otherwise; acceptance SHALL fire exactly once per stable word, at the edge where the word has been unchanged for STABLE_CYCLES cycles.
REQ-014 Input held constant from before edge 0 SHALL be accepted at edge 2+STABLE_CYCLES.
REQ-015 An accepted word with row_sel == 0 (blank) SHALL be ignored: no write, no error, no state change.
REQ-016 An accepted word with more than one row_sel bit set SHALL raise err_pulse and increment err_count in any state, force HUNT, and write nothing.
REQ-017 The FSM SHALL have two states: HUNT and CAPTURE; reset state is HUNT.
REQ-018 In HUNT, an accepted row 0 SHALL write ~col_n to capture slot 0, set last_row=0, set expect=1, and enter CAPTURE; other one-hot rows SHALL be ignored without error.
REQ-019 In CAPTURE, an accepted row equal to last_row SHALL be ignored, with no write and no error.
REQ-020 In CAPTURE, an accepted row equal to expect SHALL write ~col_n to slot expect, set last_row=expect, and advance expect modulo 10.
REQ-021 In CAPTURE, any other one-hot row SHALL raise err_pulse, increment err_count, and enter HUNT.
REQ-022 Writing slot 9 SHALL copy all ten capture slots to the committed buffer, including slot 9's new value, on the same edge.
REQ-023 On that same edge, the commit SHALL raise frame_valid for one cycle and increment frame_count; the FSM SHALL remain in CAPTURE with expect=0.
REQ-024 rd_data SHALL be registered with one-cycle latency from rd_row.
REQ-025 rd_row values 10..15 SHALL return 0.
REQ-026 A read sampled on a commit edge SHALL return the pre-commit committed contents.
REQ-027 The committed buffer SHALL change only on a commit; an aborted, partial frame SHALL never reach the committed buffer.
REQ-028 err_count SHALL hold at 255 on further errors; err_pulse SHALL still fire.

Reset
REQ-029 While rst_n is low, all outputs, both buffers, synchronizers, stability counter, last_row, expect, and counters SHALL be 0, and the FSM SHALL be in HUNT.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame; after release, capture SHALL restart only at row 0.

Verification
REQ-031 Scan rows 0..9 in order, col_n=~(10'h001<<r), each held 8 cycles, STABLE_CYCLES=4 -> one frame_valid pulse, frame_count=1, rd_data(r)=1<<r one cycle after rd_row=r.
REQ-032 Hold row_sel=10'h003 for 10 cycles during CAPTURE -> err_pulse once, err_count=1, FSM in HUNT, committed buffer unchanged.
REQ-033 Glitch col_n for 2 cycles inside a held row with STABLE_CYCLES=4 -> glitch value not written; restored value is not re-written because it is a repeat of last_row.
REQ-034 Scan rows 0,1,2 then 5 -> err_pulse, HUNT; then a full 0..9 sequence -> frame_count increments by exactly 1.
REQ-035 Pulse rst_n low during row 6 -> all outputs 0 immediately; a sequence starting at row 3 after release produces no writes until row 0 is accepted.
REQ-036 Inject 300 multi-hot errors -> err_count=255 and 300 err_pulses.
